// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit 7-segment scan controller with debounced mode/select buttons
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] SW0,
  input  logic [3:0] SW1,
  input  logic [3:0] SW2,
  input  logic [3:0] SW3,
  input  logic [1:0] BTN,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       MODE,
  output logic [1:0] CUR_DIGIT
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(REFRESH_DIV);
  typedef enum logic {SCAN = 1'b0, SINGLE = 1'b1} mode_t;
  mode_t state, state_nx;
  logic [1:0] s1, s2, db, db_d, press;
  logic [DW-1:0] cnt [2];
  logic [PW-1:0] pre;
  logic tick, chg, mode_q;
  logic [1:0] scan_idx, sel_idx, act, act_q;
  logic [3:0] sw;
  logic [6:0] dec;
  // synchronize buttons and accept a level only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end
  // mode state register
  always_ff @(posedge clk) state <= rst ? SCAN : state_nx;
  // press pulses, mode toggle, active digit selection and decode
  always_comb begin
    press = db & ~db_d;
    state_nx = press[0] ? mode_t'(~state) : state;
    tick = pre == PW'(REFRESH_DIV - 1);
    act = (state == SINGLE) ? sel_idx : scan_idx;
    chg = (act != act_q) || (state != mode_q);
    sw = act == 2'd0 ? SW0 : act == 2'd1 ? SW1 : act == 2'd2 ? SW2 : SW3;
    dec = 7'b1111111;
    case (sw)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'b1111111;
    endcase
  end
  // refresh/select indices and registered outputs; anodes blank one cycle after any index change
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      scan_idx <= '0;
      sel_idx <= '0;
      act_q <= '0;
      mode_q <= 1'b0;
      AN <= 4'b1111;
      SEG <= 7'b1111111;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      scan_idx <= scan_idx + 2'(tick);
      sel_idx <= sel_idx + 2'(press[1]);
      act_q <= act;
      mode_q <= state;
      AN <= chg ? 4'b1111 : ~(4'b0001 << act);
      SEG <= dec;
    end
  end
  assign MODE = state;
  assign CUR_DIGIT = act;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed table-driven bench for the 7-segment scan controller
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] SW0, SW1, SW2, SW3;
  logic [1:0] BTN;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic MODE;
  logic [1:0] CUR_DIGIT;
  int checks = 0, errors = 0;

  typedef struct {logic [3:0] an; logic [6:0] seg; logic [1:0] cur;} vec_t;
  vec_t tv [20];

  seg7_scan_ctrl #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3), .BTN(BTN),
    .AN(AN), .SEG(SEG), .MODE(MODE), .CUR_DIGIT(CUR_DIGIT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] b);
    BTN = b;
    repeat (6) @(posedge clk);
    BTN = 2'b00;
    repeat (7) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{4'b1110, 7'b0110000, 2'd0};
    tv[1]  = '{4'b1110, 7'b0110000, 2'd0};
    tv[2]  = '{4'b1110, 7'b0110000, 2'd0};
    tv[3]  = '{4'b1110, 7'b0110000, 2'd1};
    tv[4]  = '{4'b1111, 7'b0000010, 2'd1};
    tv[5]  = '{4'b1101, 7'b0000010, 2'd1};
    tv[6]  = '{4'b1101, 7'b0000010, 2'd1};
    tv[7]  = '{4'b1101, 7'b0000010, 2'd2};
    tv[8]  = '{4'b1111, 7'b0000000, 2'd2};
    tv[9]  = '{4'b1011, 7'b0000000, 2'd2};
    tv[10] = '{4'b1011, 7'b0000000, 2'd2};
    tv[11] = '{4'b1011, 7'b0000000, 2'd3};
    tv[12] = '{4'b1111, 7'b0010000, 2'd3};
    tv[13] = '{4'b0111, 7'b0010000, 2'd3};
    tv[14] = '{4'b0111, 7'b0010000, 2'd3};
    tv[15] = '{4'b0111, 7'b0010000, 2'd0};
    tv[16] = '{4'b1111, 7'b0110000, 2'd0};
    tv[17] = '{4'b1110, 7'b0110000, 2'd0};
    tv[18] = '{4'b1110, 7'b0110000, 2'd0};
    tv[19] = '{4'b1110, 7'b0110000, 2'd1};
    SW0 = 4'h3; SW1 = 4'h6; SW2 = 4'h8; SW3 = 4'h9;
    BTN = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    chk("reset_an", AN, 4'b1111);
    chk("reset_seg", SEG, 7'b1111111);
    chk("reset_mode", MODE, 1'b0);
    chk("reset_cur", CUR_DIGIT, 2'd0);
    rst = 1'b0;
    BTN = 2'b00;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk($sformatf("scan_an[%0d]", k), AN, tv[k].an);
      chk($sformatf("scan_seg[%0d]", k), SEG, tv[k].seg);
      chk($sformatf("scan_cur[%0d]", k), CUR_DIGIT, tv[k].cur);
      chk($sformatf("scan_mode[%0d]", k), MODE, 1'b0);
    end
    BTN = 2'b01;
    repeat (2) @(posedge clk);
    BTN = 2'b00;
    cyc(8);
    chk("glitch_mode", MODE, 1'b0);
    BTN = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (c == 5) chk("deb_mode_before", MODE, 1'b0);
      if (c == 6) chk("deb_mode_after", MODE, 1'b1);
    end
    repeat (10) @(posedge clk);
    BTN = 2'b00;
    cyc(10);
    chk("hold_release_mode", MODE, 1'b1);
    chk("single_d0_an", AN, 4'b1110);
    press(2'b10);
    press(2'b10);
    chk("sel2_cur", CUR_DIGIT, 2'd2);
    chk("sel2_seg", SEG, 7'b0000000);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("sel2_steady_an[%0d]", c), AN, 4'b1011);
      cyc(1);
    end
    BTN = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (c == 6) begin
        chk("sel3_cur", CUR_DIGIT, 2'd3);
        chk("sel3_an_old", AN, 4'b1011);
      end
      if (c == 7) begin
        chk("sel3_ghost_an", AN, 4'b1111);
        chk("sel3_ghost_seg", SEG, 7'b0010000);
      end
      if (c == 8) chk("sel3_an_new", AN, 4'b0111);
    end
    BTN = 2'b00;
    cyc(7);
    press(2'b10);
    chk("wrap_cur", CUR_DIGIT, 2'd0);
    chk("wrap_an", AN, 4'b1110);
    chk("wrap_seg", SEG, 7'b0110000);
    SW0 = 4'h1;
    cyc(1);
    chk("live_seg_1", SEG, 7'b1111001);
    SW0 = 4'hF;
    cyc(1);
    chk("live_seg_f", SEG, 7'b0001110);
    BTN = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (c == 5) chk("simul_mode_before", MODE, 1'b1);
      if (c == 6) chk("simul_mode_after", MODE, 1'b0);
    end
    BTN = 2'b00;
    cyc(7);
    press(2'b01);
    chk("simul_sel_mode", MODE, 1'b1);
    chk("simul_sel_cur", CUR_DIGIT, 2'd1);
    chk("simul_sel_an", AN, 4'b1101);
    chk("simul_sel_seg", SEG, 7'b0000010);
    press(2'b10);
    chk("pre_rst_cur", CUR_DIGIT, 2'd2);
    BTN = 2'b11;
    rst = 1'b1;
    cyc(1);
    chk("midrst_mode", MODE, 1'b0);
    chk("midrst_cur", CUR_DIGIT, 2'd0);
    chk("midrst_an", AN, 4'b1111);
    chk("midrst_seg", SEG, 7'b1111111);
    rst = 1'b0;
    BTN = 2'b00;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk($sformatf("restart_an[%0d]", k), AN, k < 4 ? 4'b1110 : k == 4 ? 4'b1111 : 4'b1101);
      chk($sformatf("restart_seg[%0d]", k), SEG, k < 4 ? 7'b0001110 : 7'b0000010);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Controller that sequences the board's 4-digit 7-segment display from four 4-bit switch groups (SW0..SW3).
- Time-multiplexes the digits on a refresh counter and debounces the two push buttons.
- Buttons toggle between automatic scan of all digits and a single held digit, and choose which digit is held.
- Sits between the raw board I/O (switches, buttons) and the AN/SEG display pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SW0  in  4  digit 0 value
- SW1  in  4  digit 1 value
- SW2  in  4  digit 2 value
- SW3  in  4  digit 3 value
- BTN  in  2  raw buttons, asynchronous to clk; BTN[0]=mode toggle, BTN[1]=select advance
- AN  out  4  digit anodes, active low; AN[i] enables digit i
- SEG  out  7  segments, active low, {g,f,e,d,c,b,a}
- MODE  out  1  0=SCAN, 1=SINGLE
- CUR_DIGIT  out  2  index of the digit currently addressed

Behaviour:
- Reset (rst sampled high at a clk edge) sets:
  - AN=4'b1111, SEG=7'b1111111, MODE=0, CUR_DIGIT=0
  - prescaler=0, scan_idx=0, sel_idx=0
  - synchronizers, debounce counters and debounced levels all 0
- Reset mid-operation: everything returns to these values on that edge, regardless of button state.
- Input conditioning:
  - Each BTN bit passes through a 2-FF synchronizer.
  - Per-button debounce counter counts while the synchronized level differs from the debounced level, and clears on any agreement.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A one-cycle press pulse is generated on each debounced 0->1 transition; releases produce no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle the count equals REFRESH_DIV-1.
- scan_idx: increments on tick, wrapping 3->0. It runs in both modes.
- Mode state machine:
  - States SCAN (0) and SINGLE (1); reset state is SCAN.
  - A BTN[0] press pulse toggles the state.
  - MODE reflects the state one cycle after the pulse.
- sel_idx: increments on a BTN[1] press pulse, wrapping 3->0. It updates in both modes but is visible only in SINGLE.
- Simultaneous BTN[0] and BTN[1] pulses in one cycle: both take effect in that cycle.
- Active index: scan_idx in SCAN, sel_idx in SINGLE; CUR_DIGIT = active index.
- Output stage (registered):
  - SEG = decoded hex pattern of the active digit's SW group, one cycle after the index or SW changes.
  - AN is one-hot-low for the active index.
  - Ghost guard: in the cycle after any active-index change (tick in SCAN, sel change, mode change), AN=1111 for exactly one cycle while SEG already carries the new pattern. The new AN asserts the following cycle.
  - Net effect in SCAN: each digit is lit REFRESH_DIV-1 of every REFRESH_DIV cycles.
- Hex decode, full 0-F, active low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- SW inputs are quasi-static and are not synchronized; a change is reflected within one cycle.

Test Plan (bench uses REFRESH_DIV=4, DEBOUNCE_CYCLES=3):
- Reset: hold rst 2 cycles with BTN=11 and SW0=3 -> AN=1111, SEG=1111111, MODE=0, CUR_DIGIT=0. After release, AN=1110 with SEG=0110000 appears within 6 cycles.
- Scan: SW0=3, SW1=6, SW2=8, SW3=9, BTN=00 -> repeating AN 1110/1101/1011/0111 with SEG 0110000/0000010/0000000/0010000. Each digit is lit 3 cycles, separated by one AN=1111 cycle, and wraps after digit 3.
- Debounce: BTN[0] high for 2 cycles then low -> MODE stays 0. BTN[0] held 8 cycles -> MODE=1 exactly once. Holding it longer and releasing causes no further toggle.
- Single select: MODE=1, two BTN[1] presses -> CUR_DIGIT=2 and AN steady at 1011 (no scanning) with SEG=0000000 (SW2=8). Two more presses -> wraps to AN=1110. Each index change shows one AN=1111 cycle.
- Live update and simultaneous buttons: in SINGLE on digit 0, set SW0=1 -> SEG=1111001 next cycle; set SW0=F -> SEG=0001110. Pressing BTN[0] and BTN[1] together -> MODE=0 and sel_idx=1 in the same cycle.
- Reset mid-operation: in SINGLE with sel_idx=2, pulse rst for 1 cycle -> MODE=0, CUR_DIGIT=0, AN=1111, SEG=1111111. Scanning then restarts from digit 0.
